// File: rtl/vector_mem_requester_pkg.sv
// Shared codes for the data-side memory requester: memory-port signal and
// status codes, element data-type codes, and the requester state encoding.
package vector_mem_requester_pkg;

  // Memory-port request codes driven on d_cache_mem_vis_signal.
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  // Memory-port status codes returned on mem_status.
  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd1;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd2;

  // Element width codes.
  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_ISSUE = 2'd1,
    REQ_WAIT  = 2'd2,
    REQ_DONE  = 2'd3
  } req_state_e;

  // Only 1/2/4-byte elements fit a single 32-bit beat.
  function automatic logic dtype_is_legal(input logic [2:0] dt);
    case (dt)
      ONE_BYTE, TWO_BYTE, FOUR_BYTE: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // log2 of the element stride in bytes.
  function automatic logic [1:0] dtype_shift(input logic [2:0] dt);
    case (dt)
      ONE_BYTE:  return 2'd0;
      TWO_BYTE:  return 2'd1;
      FOUR_BYTE: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_swizzle.sv
// Byte-order conversion between memory order (lowest address in bits [31:24])
// and little-endian element order, for one 32-bit beat.
module mem_byte_swizzle
  import vector_mem_requester_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [2:0]          data_type_i,
  input  logic [DATA_LEN-1:0] mem_data_i,
  input  logic [DATA_LEN-1:0] elem_i,
  output logic [DATA_LEN-1:0] rd_elem_o,
  output logic [DATA_LEN-1:0] wr_beat_o
);

  logic [7:0] b0_s;
  logic [7:0] b1_s;
  logic [7:0] b2_s;
  logic [7:0] b3_s;

  assign b0_s = mem_data_i[31:24];
  assign b1_s = mem_data_i[23:16];
  assign b2_s = mem_data_i[15:8];
  assign b3_s = mem_data_i[7:0];

  // Extract a zero-extended little-endian element from a memory-order beat.
  always_comb begin
    rd_elem_o = '0;
    case (data_type_i)
      ONE_BYTE:  rd_elem_o = {24'd0, b0_s};
      TWO_BYTE:  rd_elem_o = {16'd0, b1_s, b0_s};
      FOUR_BYTE: rd_elem_o = {b3_s, b2_s, b1_s, b0_s};
      default:   rd_elem_o = '0;
    endcase
  end

  // Byte-reverse the element so its low byte lands at the lowest address;
  // memory only commits the leading data_type bytes of the beat.
  always_comb begin
    wr_beat_o = {elem_i[7:0], elem_i[15:8], elem_i[23:16], elem_i[31:24]};
  end

endmodule

// File: rtl/vector_mem_requester.sv
// Serialises one scalar/vector LSU load or store into single-element beats on
// the data-cache memory port, honouring the element mask and retrying beats
// that lose arbitration to the instruction side.
module vector_mem_requester
  import vector_mem_requester_pkg::*;
#(
  parameter int ADDR_WIDTH       = 20,
  parameter int DATA_LEN         = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [ENTRY_INDEX_SIZE:0]       req_length,
  input  logic [2:0]                      req_data_type,
  input  logic [VECTOR_SIZE-1:0]          req_mask,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] req_wdata,
  output logic                            resp_done,
  output logic                            resp_error,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] resp_rdata,
  output logic [1:0]                      d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]           d_cache_mem_vis_addr,
  output logic [ENTRY_INDEX_SIZE:0]       length,
  output logic [DATA_LEN-1:0]             written_data,
  output logic [2:0]                      data_type,
  input  logic [DATA_LEN-1:0]             mem_data,
  input  logic [1:0]                      mem_status
);

  localparam int IW = ENTRY_INDEX_SIZE + 1;
  localparam logic [IW-1:0] IDX_STEP = IW'(1);
  localparam logic [IW-1:0] MAX_LEN  = IW'(VECTOR_SIZE);

  typedef logic [VECTOR_SIZE-1:0][DATA_LEN-1:0] vec_t;

  // FSM and latched request
  req_state_e               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     write_q, write_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [IW-1:0]            len_q, len_d;
  logic [2:0]               dt_q, dt_d;
  logic [VECTOR_SIZE-1:0]   mask_q, mask_d;
  vec_t                     wdata_q, wdata_d;

  // Registered response and memory-port outputs
  vec_t                     rdata_q, rdata_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [1:0]               sig_q, sig_d;
  logic [ADDR_WIDTH-1:0]    vis_addr_q, vis_addr_d;
  logic [DATA_LEN-1:0]      wbeat_q, wbeat_d;
  logic [2:0]               dto_q, dto_d;

  // Datapath helpers
  logic [ENTRY_INDEX_SIZE-1:0] idx_lo_s;
  logic [IW-1:0]               idx_inc_s;
  logic [ADDR_WIDTH-1:0]       beat_addr_s;
  logic                        req_illegal_s;
  logic [DATA_LEN-1:0]         rd_elem_s;
  logic [DATA_LEN-1:0]         pack_s;

  assign idx_lo_s      = idx_q[ENTRY_INDEX_SIZE-1:0];
  assign idx_inc_s     = idx_q + IDX_STEP;
  assign beat_addr_s   = base_q + (ADDR_WIDTH'(idx_q) << dtype_shift(dt_q));
  assign req_illegal_s = !dtype_is_legal(req_data_type) || (req_length > MAX_LEN);

  mem_byte_swizzle #(
    .DATA_LEN (DATA_LEN)
  ) u_swizzle (
    .data_type_i (dt_q),
    .mem_data_i  (mem_data),
    .elem_i      (wdata_q[idx_lo_s]),
    .rd_elem_o   (rd_elem_s),
    .wr_beat_o   (pack_s)
  );

  // Next-state, beat issue and element collection.
  // Reaching the final index jumps straight to DONE so the response pulse
  // appears without an extra ISSUE cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    base_d     = base_q;
    len_d      = len_q;
    dt_d       = dt_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    done_d     = 1'b0;
    sig_d      = MEM_NOP;
    vis_addr_d = vis_addr_q;
    wbeat_d    = wbeat_q;
    dto_d      = dto_q;
    case (state_q)
      REQ_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          base_d  = req_addr;
          len_d   = req_length;
          dt_d    = req_data_type;
          mask_d  = req_mask;
          wdata_d = req_wdata;
          rdata_d = '0;
          idx_d   = '0;
          error_d = 1'b0;
          if (req_illegal_s) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = REQ_DONE;
          end else if (req_length == '0) begin
            done_d  = 1'b1;
            state_d = REQ_DONE;
          end else begin
            state_d = REQ_ISSUE;
          end
        end else begin
          state_d = REQ_IDLE;
        end
      end
      REQ_ISSUE: begin
        if (idx_q >= len_q) begin
          done_d  = 1'b1;
          state_d = REQ_DONE;
        end else if (!mask_q[idx_lo_s]) begin
          idx_d = idx_inc_s;
          if (idx_inc_s == len_q) begin
            done_d  = 1'b1;
            state_d = REQ_DONE;
          end else begin
            state_d = REQ_ISSUE;
          end
        end else begin
          sig_d      = write_q ? MEM_WRITE : MEM_READ;
          vis_addr_d = beat_addr_s;
          wbeat_d    = pack_s;
          dto_d      = dt_q;
          state_d    = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        case (mem_status)
          MEM_DATA_FINISHED: begin
            if (!write_q) begin
              rdata_d[idx_lo_s] = rd_elem_s;
            end else begin
              rdata_d = rdata_q;
            end
            idx_d = idx_inc_s;
            if (idx_inc_s == len_q) begin
              done_d  = 1'b1;
              state_d = REQ_DONE;
            end else begin
              state_d = REQ_ISSUE;
            end
          end
          MEM_INST_FINISHED: state_d = REQ_ISSUE;
          default:           state_d = REQ_WAIT;
        endcase
      end
      REQ_DONE: state_d = REQ_IDLE;
      default:  state_d = REQ_IDLE;
    endcase
  end

  // State, request latch and registered outputs; reset aborts any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ_IDLE;
      idx_q      <= '0;
      write_q    <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      dt_q       <= ONE_BYTE;
      mask_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      sig_q      <= MEM_NOP;
      vis_addr_q <= '0;
      wbeat_q    <= '0;
      dto_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      base_q     <= base_d;
      len_q      <= len_d;
      dt_q       <= dt_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      sig_q      <= sig_d;
      vis_addr_q <= vis_addr_d;
      wbeat_q    <= wbeat_d;
      dto_q      <= dto_d;
    end
  end

  assign req_ready              = (state_q == REQ_IDLE);
  assign resp_done              = done_q;
  assign resp_error             = error_q;
  assign resp_rdata             = rdata_q;
  assign d_cache_mem_vis_signal = sig_q;
  assign d_cache_mem_vis_addr   = vis_addr_q;
  assign written_data           = wbeat_q;
  assign data_type              = dto_q;
  assign length                 = IDX_STEP;

endmodule

// File: tb/tb_vector_mem_requester.sv
// Randomised self-checking bench for vector_mem_requester with a byte-array
// memory responder and an element-level reference model.
module tb_vector_mem_requester;
  import vector_mem_requester_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write;
  logic [19:0]  req_addr;
  logic [3:0]   req_length;
  logic [2:0]   req_data_type;
  logic [7:0]   req_mask;
  logic [255:0] req_wdata;
  logic         resp_done, resp_error;
  logic [255:0] resp_rdata;
  logic [1:0]   d_cache_mem_vis_signal;
  logic [19:0]  d_cache_mem_vis_addr;
  logic [3:0]   length;
  logic [31:0]  written_data;
  logic [2:0]   data_type;
  logic [31:0]  mem_data;
  logic [1:0]   mem_status;

  always #5 clk = ~clk;

  vector_mem_requester #(
    .ADDR_WIDTH(20), .DATA_LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_length(req_length), .req_data_type(req_data_type),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .d_cache_mem_vis_signal(d_cache_mem_vis_signal), .d_cache_mem_vis_addr(d_cache_mem_vis_addr),
    .length(length), .written_data(written_data), .data_type(data_type),
    .mem_data(mem_data), .mem_status(mem_status)
  );

  logic [7:0] mem     [0:(1<<20)-1];
  logic [7:0] ref_mem [0:(1<<20)-1];

  int checks = 0;
  int errors = 0;

  // Memory responder configuration (written by the stimulus process only).
  int cfg_lat      = 0;
  int retry_budget = 0;
  // Memory responder bookkeeping (written by the responder process only).
  int          retry_used = 0;
  int          sig_cycles = 0;
  int          bus_viol   = 0;
  logic [19:0] last_addr  = 20'd0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: sees each beat request, optionally loses it to the
  // instruction side, otherwise answers after cfg_lat resting cycles.
  initial begin
    logic        pend;
    int          cnt;
    logic [1:0]  p_sig;
    logic [19:0] p_addr;
    logic [31:0] p_wd;
    logic [2:0]  p_dt;
    int          nb;
    pend = 1'b0; cnt = 0; p_sig = MEM_NOP; p_addr = 20'd0; p_wd = 32'd0; p_dt = 3'd0;
    mem_status = MEM_RESTING;
    mem_data   = 32'd0;
    forever begin
      @(negedge clk);
      mem_status = MEM_RESTING;
      mem_data   = $urandom;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (d_cache_mem_vis_signal != MEM_NOP) begin
          sig_cycles++;
          if (pend) bus_viol++;
          pend = 1'b1; cnt = cfg_lat;
          p_sig = d_cache_mem_vis_signal; p_addr = d_cache_mem_vis_addr;
          p_wd = written_data; p_dt = data_type;
          last_addr = d_cache_mem_vis_addr;
        end
        if (pend) begin
          if (cnt != 0) begin
            cnt--;
          end else begin
            pend = 1'b0;
            if (retry_used < retry_budget) begin
              retry_used++;
              mem_status = MEM_INST_FINISHED;
              mem_data   = 32'hDEADBEEF;
            end else begin
              mem_status = MEM_DATA_FINISHED;
              if (p_sig == MEM_READ) begin
                mem_data = {mem[p_addr], mem[p_addr + 20'd1], mem[p_addr + 20'd2], mem[p_addr + 20'd3]};
              end else begin
                nb = (p_dt == ONE_BYTE) ? 1 : (p_dt == TWO_BYTE) ? 2 : 4;
                for (int k = 0; k < nb; k++) mem[p_addr + 20'(k)] = p_wd[31 - 8*k -: 8];
              end
            end
          end
        end
      end
    end
  end

  // One request end to end, checked against the element-level model.
  task automatic run_req(input string tag, input logic w, input logic [19:0] a, input logic [3:0] len,
                         input logic [2:0] dt, input logic [7:0] m, input logic [255:0] wd,
                         input int lat, input int rt);
    int n, s, exp_cyc, cyc, nb, sig0, waitc, bad;
    logic ill;
    logic [255:0] exp_rd;
    logic [31:0] e;
    logic [19:0] ea;
    ill = (dt != ONE_BYTE && dt != TWO_BYTE && dt != FOUR_BYTE) || (len > 4'd8);
    nb  = (dt == ONE_BYTE) ? 1 : (dt == TWO_BYTE) ? 2 : 4;
    n = 0; s = 0; exp_rd = '0;
    if (!ill) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(len)) begin
          if (m[i]) begin
            n++;
            if (!w) begin
              e = 32'd0;
              for (int k = 0; k < nb; k++) begin
                ea = a + 20'(i*nb + k);
                e[8*k +: 8] = ref_mem[ea];
              end
              exp_rd[32*i +: 32] = e;
            end
          end else begin
            s++;
          end
        end
      end
    end
    if (n == 0) rt = 0;
    exp_cyc = ill ? 1 : 1 + s + (n + rt) * (2 + lat);

    waitc = 0;
    while (!req_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
    check({tag, "_ready"}, req_ready, 1'b1);
    cfg_lat = lat;
    retry_budget = retry_budget + rt;
    sig0 = sig_cycles;

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_length = len;
    req_data_type = dt; req_mask = m; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = '0;
    cyc = 1;
    if (exp_cyc > 1) check({tag, "_busy"}, req_ready, 1'b0);
    while (!resp_done && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check({tag, "_done"}, resp_done, 1'b1);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_error"}, resp_error, ill);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    @(posedge clk); #1;
    check({tag, "_pulse"}, resp_done, 1'b0);
    check({tag, "_hold"}, resp_rdata, exp_rd);
    check({tag, "_beats"}, sig_cycles - sig0, n + rt);

    if (w && !ill) begin
      for (int i = 0; i < 8; i++)
        if (i < int'(len) && m[i])
          for (int k = 0; k < nb; k++) ref_mem[a + 20'(i*nb + k)] = wd[32*i + 8*k +: 8];
      bad = 0;
      for (int j = -4; j < 40; j++) begin
        ea = a + 20'(j);
        if (mem[ea] !== ref_mem[ea]) bad++;
      end
      check({tag, "_memory"}, bad, 0);
    end
  endtask

  // Abort watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus: reset, directed cases, mid-request reset, random requests.
  initial begin
    logic [255:0] wd;
    logic         w;
    logic [19:0]  a;
    logic [3:0]   len;
    logic [2:0]   dt;
    logic [7:0]   m;
    int           sel, dones;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 20'd0; req_length = 4'd0;
    req_data_type = 3'd0; req_mask = 8'd0; req_wdata = '0;
    for (int i = 0; i < (1<<20); i++) begin mem[i] = 8'(i); ref_mem[i] = 8'(i); end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_done", resp_done, 1'b0);
    check("rst_error", resp_error, 1'b0);
    check("rst_rdata", resp_rdata, 256'd0);
    check("rst_signal", d_cache_mem_vis_signal, MEM_NOP);
    check("rst_addr", d_cache_mem_vis_addr, 20'd0);
    check("rst_wdata", written_data, 32'd0);
    check("rst_dtype", data_type, 3'd0);
    check("rst_length", length, 4'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Four-byte vector load.
    run_req("ld4", 1'b0, 20'h00100, 4'd4, FOUR_BYTE, 8'h0F, '0, 0, 0);
    check("ld4_e0", resp_rdata[31:0], 32'h03020100);
    check("ld4_e3", resp_rdata[127:96], 32'h0F0E0D0C);

    // Masked two-byte store.
    wd = '0; wd[31:0] = 32'h0000BEEF; wd[95:64] = 32'h00001234;
    run_req("st2", 1'b1, 20'h00200, 4'd3, TWO_BYTE, 8'h05, wd, 0, 0);
    check("st2_200", mem[20'h00200], 8'hEF);
    check("st2_201", mem[20'h00201], 8'hBE);
    check("st2_202", mem[20'h00202], 8'h02);
    check("st2_203", mem[20'h00203], 8'h03);
    check("st2_204", mem[20'h00204], 8'h34);
    check("st2_205", mem[20'h00205], 8'h12);

    // First beat lost to the instruction side, then retried.
    run_req("retry", 1'b0, 20'h00100, 4'd2, FOUR_BYTE, 8'h03, '0, 0, 1);
    check("retry_e1", resp_rdata[63:32], 32'h07060504);

    // Byte load wrapping past the top of memory.
    mem[20'h00000] = 8'h5A; ref_mem[20'h00000] = 8'h5A;
    run_req("wrap", 1'b0, 20'hFFFFF, 4'd2, ONE_BYTE, 8'h03, '0, 0, 0);
    check("wrap_elems", resp_rdata[63:0], 64'h0000005A_000000FF);
    check("wrap_addr", last_addr, 20'h00000);

    // Degenerate and illegal requests.
    run_req("len0", 1'b0, 20'h00300, 4'd0, FOUR_BYTE, 8'hFF, '0, 0, 0);
    run_req("eight", 1'b0, 20'h00300, 4'd2, EIGHT_BYTE, 8'hFF, '0, 0, 0);
    run_req("len9", 1'b1, 20'h00300, 4'd9, ONE_BYTE, 8'hFF, '1, 0, 0);
    run_req("allmask", 1'b0, 20'h00300, 4'd3, TWO_BYTE, 8'h00, '0, 0, 0);
    run_req("lat2", 1'b0, 20'h00104, 4'd3, TWO_BYTE, 8'h06, '0, 2, 0);

    // Reset while waiting on the second beat.
    @(negedge clk);
    cfg_lat = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00100; req_length = 4'd3;
    req_data_type = FOUR_BYTE; req_mask = 8'h07;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rstmid_inwait", d_cache_mem_vis_signal, MEM_READ);
    rst_n = 1'b0;
    #1;
    check("rstmid_signal", d_cache_mem_vis_signal, MEM_NOP);
    check("rstmid_ready", req_ready, 1'b1);
    check("rstmid_done", resp_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (10) begin @(posedge clk); #1; if (resp_done) dones++; end
    check("rstmid_nodone", dones, 0);

    // Random requests.
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15)) : 20'($urandom);
      sel = $urandom_range(0, 9);
      dt = (sel < 3) ? ONE_BYTE : (sel < 6) ? TWO_BYTE : (sel < 9) ? FOUR_BYTE : EIGHT_BYTE;
      len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      m = 8'($urandom);
      for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
      run_req($sformatf("rnd%0d", t), w, a, len, dt, m, wd, $urandom_range(0, 2), $urandom_range(0, 1));
    end

    check("bus_one_cycle", bus_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_requester.md
# vector_mem_requester

Data-side initiator for the main-memory port: accepts one scalar or vector load/store from the load/store unit and serialises it into single-element beats on the data-cache memory interface (`d_cache_mem_vis_signal` / `mem_status`). It sits between the LSU and main memory, in the data-cache slot. It converts memory byte order (lowest address in bits [31:24]) to and from little-endian element order. It honours a per-element mask, collects read elements into a vector buffer and returns them with a one-cycle completion pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: memory byte-address width.
- `DATA_LEN`, 32: element and beat width.
- `VECTOR_SIZE`, 8: maximum elements per request.
- `ENTRY_INDEX_SIZE`, 3: log2(VECTOR_SIZE).

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  base byte address.
- `req_length`  in  ENTRY_INDEX_SIZE+1  element count, 0..VECTOR_SIZE.
- `req_data_type`  in  3  `ONE_BYTE` / `TWO_BYTE` / `FOUR_BYTE` (`EIGHT_BYTE` is illegal).
- `req_mask`  in  VECTOR_SIZE  bit i = 1 means element i is active.
- `req_wdata`  in  VECTOR_SIZE*DATA_LEN  store elements, little-endian, element i in slice i.
- `resp_done`  out  1  one-cycle completion pulse.
- `resp_error`  out  1  valid with `resp_done`.
- `resp_rdata`  out  VECTOR_SIZE*DATA_LEN  load result, zero-extended, held until next accept.
- `d_cache_mem_vis_signal`  out  2  `MEM_NOP` / `MEM_READ` / `MEM_WRITE`.
- `d_cache_mem_vis_addr`  out  ADDR_WIDTH  beat address.
- `length`  out  ENTRY_INDEX_SIZE+1  constant 1.
- `written_data`  out  DATA_LEN  store beat in memory order.
- `data_type`  out  3  element width of current beat.
- `mem_data`  in  DATA_LEN  read beat in memory order.
- `mem_status`  in  2  `MEM_RESTING` / `MEM_DATA_FINISHED` / `MEM_INST_FINISHED`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Register `idx` (ENTRY_INDEX_SIZE+1 bits).
- IDLE: on `req_valid`, latch all request fields, clear `resp_rdata` and `idx`, then go to ISSUE.
  - `req_length` 0 goes directly to DONE.
  - `EIGHT_BYTE`, or `req_length` > VECTOR_SIZE, goes to DONE with error set; no beats are issued.
- ISSUE:
  - If `idx` == length, go to DONE.
  - Else if `mask[idx]` = 0, `idx`++ and stay in ISSUE; no memory traffic.
  - Else drive `MEM_READ` or `MEM_WRITE`, addr = base + idx*stride (stride 1/2/4), and go to WAIT.
- WAIT: drive `MEM_NOP`.
  - On `MEM_DATA_FINISHED`: for loads, write the element; `idx`++; go to ISSUE.
  - On `MEM_INST_FINISHED` (the instruction cache won the read): discard the data and return to ISSUE with the same `idx` (retry).
  - On `MEM_RESTING`: stay in WAIT.
- DONE: `resp_done` = 1 for one cycle, then go to IDLE.
- Read extraction, with b0 = `mem_data[31:24]`, b1 = `mem_data[23:16]`, b2 = `mem_data[15:8]`, b3 = `mem_data[7:0]`:
  - `ONE_BYTE` → {24'b0, b0}.
  - `TWO_BYTE` → {16'b0, b1, b0}.
  - `FOUR_BYTE` → {b3, b2, b1, b0}.
- Write packing: `written_data` = {e[7:0], e[15:8], e[23:16], e[31:24]}, so the low byte lands at the lowest address.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Masked-off elements read back as 0.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_done` 0, `resp_error` 0, `resp_rdata` 0, `d_cache_mem_vis_signal` `MEM_NOP`, `d_cache_mem_vis_addr` 0, `written_data` 0, `data_type` 0, `length` 1.
- Reset mid-request aborts at once; signal returns to `MEM_NOP`. No partial response is emitted.
- Memory outputs are registered, and the signal is asserted only in ISSUE, for exactly one cycle per attempt.
- Acceptance in cycle 0 with n active beats, s skipped elements and no retries gives `resp_done` in cycle 2n+s+1. Example: length 0 gives `resp_done` in cycle 1.
- `req_valid` outside IDLE is ignored; the LSU must hold it until `req_ready`.
- `resp_rdata` is stable from the DONE cycle until the next accept.

## Structure
- The shared defines file already provides `MEM_*` signal and status codes and the `*_BYTE` data-type codes; add nothing new.
- The shared package gains the state encoding `REQ_IDLE` / `REQ_ISSUE` / `REQ_WAIT` / `REQ_DONE`.
- One natural sub-module: `mem_byte_swizzle`, combinational, performing read extraction and write packing by `data_type`.

## Test plan
- Load `FOUR_BYTE`, addr 0x100, length 4, mask 0xF, memory 0x100..0x10F = 00..0F → element0 0x03020100, element3 0x0F0E0D0C; `resp_done` in cycle 9.
- Store `TWO_BYTE`, addr 0x200, length 3, mask 0b101, wdata element0 0xBEEF, element2 0x1234 → memory 0x200 = EF, 0x201 = BE, 0x204 = 34, 0x205 = 12; 0x202/0x203 untouched; `resp_done` in cycle 6.
- Load with `i_cache_mem_vis_signal` = `MEM_READ` during the first beat → `MEM_INST_FINISHED` observed, beat retried, final data correct, one extra 2-cycle attempt.
- Load `ONE_BYTE`, addr 0xFFFFF, length 2 → second beat at 0x00000 (wrap); elements zero-extended.
- `req_length` 0 → `resp_done` in cycle 1, no memory traffic. `EIGHT_BYTE` → `resp_done` and `resp_error` in cycle 1.
- `rst_n` low during WAIT of beat 2 → next cycle signal `MEM_NOP`, `req_ready` 1, no `resp_done`.
